// File: rtl/sync_fifo_flags_pkg.sv
// rtl/sync_fifo_flags_pkg.sv - shared constants for the flagged synchronous FIFO
package sync_fifo_flags_pkg;

  // Largest supported address width (depth 1024)
  localparam int FIFO_MAX_ABITS = 10;

  // Read-mode encodings for the FWFT parameter
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bus of the flagged synchronous FIFO
interface sync_fifo_flags_if #(
  parameter int ABITS = 2,
  parameter int DBITS = 8
);

  logic             flush;
  logic             wr;
  logic             rd;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [ABITS:0]   count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side
  modport master (
    output flush, wr, rd, din,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  flush, wr, rd, din,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flags_regarray.sv
// rtl/sync_fifo_flags_regarray.sv - register array, one sync write port, one async read port
module fifo_regarray #(
  parameter int ABITS = 2,
  parameter int DBITS = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ABITS-1:0] i_waddr,
  input  logic [DBITS-1:0] i_wdata,
  input  logic [ABITS-1:0] i_raddr,
  output logic [DBITS-1:0] o_rdata
);

  logic [DBITS-1:0] r_mem [2**ABITS];

  // Storage write; contents are intentionally left unreset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised single-clock FIFO with count, threshold and error flags
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int ABITS     = 2,
  parameter int DBITS     = 8,
  parameter int AFULL_TH  = 2**ABITS - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = FIFO_STD
) (
  input  logic clock,
  input  logic reset_n,
  sync_fifo_flags_if.slave bus
);

  localparam logic [ABITS:0] LP_DEPTH     = (ABITS+1)'(2**ABITS);
  localparam logic [ABITS:0] LP_AFULL_TH  = (ABITS+1)'(AFULL_TH);
  localparam logic [ABITS:0] LP_AEMPTY_TH = (ABITS+1)'(AEMPTY_TH);
  localparam logic [ABITS:0] LP_ONE       = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] LP_PTR_ONE = ABITS'(1);
  // An empty FIFO already satisfies "count >= 0" when the threshold is zero
  localparam logic LP_AFULL_RST = (AFULL_TH == 0);

  logic [ABITS-1:0] r_wp;
  logic [ABITS-1:0] r_rp;
  logic [ABITS:0]   r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_aempty;
  logic             r_afull;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [ABITS:0]   w_count_next;
  logic [DBITS-1:0] w_rdata;

  // A write into a full FIFO is still taken when a read frees the head slot
  assign w_rd_ok = bus.rd & ~r_empty;
  assign w_wr_ok = bus.wr & (~r_full | w_rd_ok);

  // Occupancy for the next cycle; simultaneous accept leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_next = r_count + LP_ONE;
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_next = r_count - LP_ONE;
    end
  end

  fifo_regarray #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_regarray (
    .i_clk   (clock),
    .i_we    (w_wr_ok & ~bus.flush),
    .i_waddr (r_wp),
    .i_wdata (bus.din),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  // Pointers, count, registered flags and sticky errors; flush beats wr/rd
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_aempty    <= 1'b1;
      r_afull     <= LP_AFULL_RST;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_aempty    <= 1'b1;
      r_afull     <= LP_AFULL_RST;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wp <= r_wp + LP_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rp <= r_rp + LP_PTR_ONE;
      end
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_full   <= (w_count_next == LP_DEPTH);
      r_aempty <= (w_count_next <= LP_AEMPTY_TH);
      r_afull  <= (w_count_next >= LP_AFULL_TH);
      if (bus.wr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word shown straight from the array; zero while nothing is held
      assign bus.dout = r_empty ? '0 : w_rdata;
    end else begin : g_std
      logic [DBITS-1:0] r_dout;

      // Registered read: capture the head word on an accepted pop, hold otherwise
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_dout <= '0;
        end else if (!bus.flush && w_rd_ok) begin
          r_dout <= w_rdata;
        end
      end

      assign bus.dout = r_dout;
    end
  endgenerate

  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_aempty;
  assign bus.almost_full  = r_afull;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
